pipe_stage_skid: RTL and testbench

- Parametrised inter-stage pipeline register for the pipelined CPU; generalises the fixed five-field stage latches (D/E, E/M, M/W).
- Carries NUM_FIELDS words of DATA_W bits with a valid/ready handshake and a one-entry skid buffer, so back-pressure no longer needs a global write-enable.
- Adds a per-field selectable flush, so a bubble can zero the instruction while keeping the PC, plus a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_skid_sat_counter.sv | 24 ++
 rtl/pipe_stage_skid.sv | 109 ++++++++++
 tb/tb_pipe_stage_skid.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: the state encoding,
// the payload field indices and the default flush mask.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   localparam int FLD_PC    = 0;
   localparam int FLD_INSTR = 1;
   localparam int FLD_IMM   = 2;
   localparam int FLD_RD1   = 3;
   localparam int FLD_RD2   = 4;

   // A bubble zeroes every field except the PC, so the PC survives a flush.
   localparam logic [4:0] FLUSH_MASK_DEFAULT = 5'b11110;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Synchronous clear takes priority over the increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a one-entry skid buffer: 1-cycle latency,
// full throughput; in_ready is registered and drops only when both entries are held.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                    DATA_W     = 32,
   parameter int                    NUM_FIELDS = 5,
   parameter logic [NUM_FIELDS-1:0] FLUSH_MASK = NUM_FIELDS'(FLUSH_MASK_DEFAULT),
   parameter int                    CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_FIELDS*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int PW = NUM_FIELDS * DATA_W;

   stage_state_e state_q, state_d;
   logic [PW-1:0] main_q, main_d;
   logic [PW-1:0] skid_q, skid_d;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          accept;
   logic          deliver;
   logic [PW-1:0] keep_mask;

   // Bits that survive a flush: all ones for fields whose mask bit is clear.
   for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_keep
      assign keep_mask[i*DATA_W +: DATA_W] = {DATA_W{~FLUSH_MASK[i]}};
   end

   assign accept  = in_valid && in_ready_q;
   assign deliver = out_valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = main_q & keep_mask;
         skid_d  = skid_q & keep_mask;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && deliver) begin
                  main_d = in_data;
               end else if (accept) begin
                  skid_d  = in_data;
                  state_d = ST_FULL;
               end else if (deliver) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (deliver) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs are flopped copies decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != ST_FULL);
         out_valid_q <= (state_d != ST_EMPTY);
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (out_valid_q && !out_ready),
      .cnt   (stall_cnt)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a queue-based model checked every cycle, plus directed literal checks.
module tb_pipe_stage_skid;

   localparam int         DW = 32;
   localparam int         NF = 5;
   localparam int         PW = DW * NF;
   localparam logic [4:0] FM = 5'b11110;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic [PW-1:0] in_data;
   logic          out_ready;
   logic          in_ready, out_valid;
   logic [PW-1:0] out_data;
   logic [15:0]   stall_cnt;
   logic          in_ready4, out_valid4;
   logic [PW-1:0] out_data4;
   logic [3:0]    stall_cnt4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .NUM_FIELDS(NF), .FLUSH_MASK(FM), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_skid #(.DATA_W(DW), .NUM_FIELDS(NF), .FLUSH_MASK(FM), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .stall_cnt(stall_cnt4)
   );

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] mk(input logic [31:0] pc, input logic [31:0] instr);
      return {pc + 32'h40, pc + 32'h30, pc + 32'h20, instr, pc};
   endfunction

   // Model: in-order list of held words, plus what the main register shows when empty.
   logic [PW-1:0] mq[$];
   logic [PW-1:0] disp;
   logic [PW-1:0] keep;
   int            cnt16, cnt4;
   bit            model_ok = 0;
   bit            m_acc, m_ov;

   initial begin
      for (int i = 0; i < NF; i++) keep[i*DW +: DW] = FM[i] ? '0 : '1;
   end

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         disp     = '0;
         cnt16    = 0;
         cnt4     = 0;
         model_ok = 1;
      end else begin
         m_ov = (mq.size() > 0);
         if (m_ov && !out_ready) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
         end
         if (flush) begin
            if (m_ov) disp = mq[0];
            disp = disp & keep;
            mq.delete();
         end else begin
            m_acc = in_valid && (mq.size() < 2);
            if (m_ov && out_ready) disp = mq.pop_front();
            if (m_acc) mq.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("out_valid", PW'(out_valid), PW'(mq.size() > 0));
         check("in_ready", PW'(in_ready), PW'(mq.size() < 2));
         check("out_data", out_data, (mq.size() > 0) ? mq[0] : disp);
         check("stall_cnt", PW'(stall_cnt), PW'(cnt16));
         check("out_valid4", PW'(out_valid4), PW'(mq.size() > 0));
         check("in_ready4", PW'(in_ready4), PW'(mq.size() < 2));
         check("out_data4", out_data4, (mq.size() > 0) ? mq[0] : disp);
         check("stall_cnt4", PW'(stall_cnt4), PW'(cnt4));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
      in_valid = v;
      in_data  = mk(pc, instr);
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {NF{32'hDEADBEEF}};

      // Reset held two cycles with junk offered.
      cyc(2);
      check("rst_out_valid", PW'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_in_ready", PW'(in_ready), PW'(1));
      check("rst_stall_cnt", PW'(stall_cnt), '0);
      reset = 1'b0;
      drive(0, 0, 0);
      cyc(1);
      check("rst_release_out_valid", PW'(out_valid), '0);

      // Streaming.
      out_ready = 1'b1;
      drive(1, 32'h3000, 32'h1);
      cyc(1);
      check("stream_pc0", PW'(out_data[31:0]), PW'(32'h3000));
      drive(1, 32'h3004, 32'h2);
      cyc(1);
      check("stream_pc1", PW'(out_data[31:0]), PW'(32'h3004));
      check("stream_in_ready", PW'(in_ready), PW'(1));
      drive(1, 32'h3008, 32'h3);
      cyc(1);
      check("stream_pc2", PW'(out_data[31:0]), PW'(32'h3008));
      check("stream_valid", PW'(out_valid), PW'(1));
      drive(0, 0, 0);
      cyc(1);
      check("stream_drain", PW'(out_valid), '0);

      // Back-pressure.
      out_ready = 1'b0;
      drive(1, 32'h3000, 32'h10);
      cyc(1);
      drive(1, 32'h3004, 32'h11);
      cyc(1);
      check("bp_in_ready_low", PW'(in_ready), '0);
      drive(1, 32'h3008, 32'h12);
      cyc(1);
      check("bp_hold_pc", PW'(out_data[31:0]), PW'(32'h3000));
      check("bp_stall2", PW'(stall_cnt), PW'(2));
      out_ready = 1'b1;
      cyc(1);
      check("bp_pc1", PW'(out_data[31:0]), PW'(32'h3004));
      cyc(1);
      check("bp_pc2", PW'(out_data[31:0]), PW'(32'h3008));
      drive(0, 0, 0);
      cyc(2);
      check("bp_stall_final", PW'(stall_cnt), PW'(2));

      // Flush from FULL.
      out_ready = 1'b0;
      drive(1, 32'h3000, 32'h8C010004);
      cyc(1);
      drive(1, 32'h3004, 32'h8C020008);
      cyc(1);
      flush = 1'b1;
      drive(1, 32'h3008, 32'h8C030000);
      cyc(1);
      flush = 1'b0;
      drive(0, 0, 0);
      check("flush_out_valid", PW'(out_valid), '0);
      check("flush_in_ready", PW'(in_ready), PW'(1));
      check("flush_out_data", out_data, PW'(32'h3000));
      out_ready = 1'b1;
      cyc(3);
      check("flush_dropped", PW'(out_valid), '0);

      // Simultaneous accept and deliver in ONE.
      out_ready = 1'b0;
      drive(1, 32'h3000, 32'h20);
      cyc(1);
      out_ready = 1'b1;
      drive(1, 32'h3004, 32'h21);
      cyc(1);
      check("ad_pc", out_data, mk(32'h3004, 32'h21));
      check("ad_in_ready", PW'(in_ready), PW'(1));
      drive(0, 0, 0);
      cyc(1);
      check("ad_empty", PW'(out_valid), '0);

      // Saturation on the 4-bit counter.
      reset = 1'b1;
      cyc(1);
      reset     = 1'b0;
      out_ready = 1'b0;
      drive(1, 32'h4000, 32'h30);
      cyc(1);
      drive(0, 0, 0);
      cyc(20);
      check("sat_15", PW'(stall_cnt4), PW'(15));
      check("sat_wide_20", PW'(stall_cnt), PW'(20));
      cyc(2);
      check("sat_hold", PW'(stall_cnt4), PW'(15));
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
      check("sat_after_flush", PW'(stall_cnt4), PW'(15));
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check("sat_after_reset", PW'(stall_cnt4), '0);
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
